framebuffer_dump_engine: RTL and testbench

//  Read-back counterpart to the UART instruction engine. On a DUMP command byte from the UART RX,

---
 rtl/framebuffer_dump_engine_pkg.sv | 32 +++
 rtl/framebuffer_dump_engine_pixel_packer.sv | 49 ++++
 rtl/framebuffer_dump_engine.sv | 141 ++++++++++++++
 tb/tb_framebuffer_dump_engine.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/framebuffer_dump_engine_pkg.sv
// Shared opcode space and framebuffer defaults for the UART instruction and dump engines.
package framebuffer_dump_engine_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_RED   = 8'h01;
  localparam logic [7:0] OP_GREEN = 8'h02;
  localparam logic [7:0] OP_BLUE  = 8'h03;
  localparam logic [7:0] OP_FRAME = 8'h04;
  localparam logic [7:0] OP_STORE = 8'h05;
  localparam logic [7:0] OP_DRAW  = 8'h06;
  localparam logic [7:0] OP_DUMP  = 8'h07;

  localparam int unsigned DEF_BITS_PER_PIXEL    = 4;
  localparam int unsigned DEF_FRAMEBUFFER_DEPTH = 640 * 480;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_SEND      = 3'd3,
    ST_WAIT_DONE = 3'd4
  } dump_state_e;

  function automatic int unsigned pixels_per_byte(input int unsigned bpp);
    return BYTE_W / bpp;
  endfunction

endpackage

// File: rtl/framebuffer_dump_engine_pixel_packer.sv
// Packs pixels into one byte, first pixel in the MSBs; unfilled low slots stay zero.
module framebuffer_dump_engine_pixel_packer
  import framebuffer_dump_engine_pkg::*;
#(
  parameter int unsigned BPP = DEF_BITS_PER_PIXEL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BPP-1:0]    pixel,
  output logic [BYTE_W-1:0] pack_byte,
  output logic              last_slot_c
);

  localparam int unsigned PPB = pixels_per_byte(BPP);

  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Each pixel lands in its own slot so a partial byte is already MSB-aligned.
  always_comb begin
    byte_d  = byte_q;
    count_d = count_q;
    if (clear) begin
      byte_d  = '0;
      count_d = '0;
    end else if (shift_en) begin
      for (int unsigned s = 0; s < PPB; s++) begin
        if (count_q == CNT_W'(s)) byte_d[BYTE_W-BPP*(s+1) +: BPP] = pixel;
      end
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q  <= '0;
      count_q <= '0;
    end else begin
      byte_q  <= byte_d;
      count_q <= count_d;
    end
  end

  assign pack_byte   = byte_q;
  assign last_slot_c = (count_q == CNT_W'(PPB - 1));

endmodule

// File: rtl/framebuffer_dump_engine.sv
// Streams the framebuffer out over UART TX, packed MSB-first, when the DUMP opcode arrives on RX.
module framebuffer_dump_engine
  import framebuffer_dump_engine_pkg::*;
#(
  parameter int unsigned BITS_PER_PIXEL    = DEF_BITS_PER_PIXEL,
  parameter int unsigned FRAMEBUFFER_DEPTH = DEF_FRAMEBUFFER_DEPTH,
  parameter logic [7:0]  DUMP_OPCODE       = OP_DUMP
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Rx_DV,
  input  logic [BYTE_W-1:0]         i_Rx_Byte,
  output logic                      o_Read_Enable,
  output logic [ADDR_W-1:0]         o_Read_Addr,
  input  logic [BITS_PER_PIXEL-1:0] i_Read_Data,
  output logic                      o_Tx_DV,
  output logic [BYTE_W-1:0]         o_Tx_Byte,
  input  logic                      i_Tx_Active,
  input  logic                      i_Tx_Done,
  output logic                      o_Busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAMEBUFFER_DEPTH - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              last_q, last_d;
  logic              read_en_q, read_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tx_dv_q, tx_dv_d;
  logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic              busy_q, busy_d;

  logic              pack_clear_c;
  logic              pack_shift_c;
  logic [BYTE_W-1:0] pack_byte;
  logic              last_slot_c;

  framebuffer_dump_engine_pixel_packer #(
    .BPP (BITS_PER_PIXEL)
  ) u_packer (
    .clk         (i_Clock),
    .rst         (i_Reset),
    .clear       (pack_clear_c),
    .shift_en    (pack_shift_c),
    .pixel       (i_Read_Data),
    .pack_byte   (pack_byte),
    .last_slot_c (last_slot_c)
  );

  // Outputs are computed one cycle ahead so the registered strobes line up with the state.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    last_d       = last_q;
    read_en_d    = 1'b0;
    addr_d       = '0;
    tx_dv_d      = 1'b0;
    tx_byte_d    = tx_byte_q;
    busy_d       = busy_q;
    pack_clear_c = 1'b0;
    pack_shift_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == DUMP_OPCODE)) begin
          state_d      = ST_READ;
          index_d      = '0;
          last_d       = 1'b0;
          busy_d       = 1'b1;
          read_en_d    = 1'b1;
          pack_clear_c = 1'b1;
        end
      end
      ST_READ: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        pack_shift_c = 1'b1;
        index_d      = index_q + ADDR_W'(1);
        if (last_slot_c || (index_q == LAST_IDX)) begin
          state_d = ST_SEND;
          last_d  = (index_q == LAST_IDX);
        end else begin
          state_d   = ST_READ;
          read_en_d = 1'b1;
          addr_d    = index_q + ADDR_W'(1);
        end
      end
      ST_SEND: begin
        if (!i_Tx_Active) begin
          state_d   = ST_WAIT_DONE;
          tx_dv_d   = 1'b1;
          tx_byte_d = pack_byte;
        end
      end
      ST_WAIT_DONE: begin
        if (i_Tx_Done) begin
          pack_clear_c = 1'b1;
          if (last_q) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d   = ST_READ;
            read_en_d = 1'b1;
            addr_d    = index_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      last_q    <= 1'b0;
      read_en_q <= 1'b0;
      addr_q    <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      last_q    <= last_d;
      read_en_q <= read_en_d;
      addr_q    <= addr_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      busy_q    <= busy_d;
    end
  end

  assign o_Read_Enable = read_en_q;
  assign o_Read_Addr   = addr_q;
  assign o_Tx_DV       = tx_dv_q;
  assign o_Tx_Byte     = tx_byte_q;
  assign o_Busy        = busy_q;

endmodule

// File: tb/tb_framebuffer_dump_engine.sv
// Directed bench: a DEPTH=10 and a DEPTH=9 engine share RX stimulus, each with its own memory and TX model.
module tb_framebuffer_dump_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        hold_active = 1'b0;

  logic        ren     [2];
  logic [31:0] raddr   [2];
  logic [3:0]  rdata   [2];
  logic        tdv     [2];
  logic [7:0]  tbyte   [2];
  logic        tactive [2];
  logic        tdone   [2];
  logic        busy    [2];
  logic        act_m   [2];
  int          tx_cnt  [2];

  logic [3:0]  mem [10];
  logic [7:0]  cap0 [$];
  logic [7:0]  cap1 [$];
  logic [31:0] rd0 [$];
  logic        busy_seen0, addr_bad, byte_unstable;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  framebuffer_dump_engine #(.BITS_PER_PIXEL(4), .FRAMEBUFFER_DEPTH(10), .DUMP_OPCODE(8'h07)) dut0 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .o_Read_Enable(ren[0]), .o_Read_Addr(raddr[0]), .i_Read_Data(rdata[0]),
    .o_Tx_DV(tdv[0]), .o_Tx_Byte(tbyte[0]), .i_Tx_Active(tactive[0]),
    .i_Tx_Done(tdone[0]), .o_Busy(busy[0]));

  framebuffer_dump_engine #(.BITS_PER_PIXEL(4), .FRAMEBUFFER_DEPTH(9), .DUMP_OPCODE(8'h07)) dut1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .o_Read_Enable(ren[1]), .o_Read_Addr(raddr[1]), .i_Read_Data(rdata[1]),
    .o_Tx_DV(tdv[1]), .o_Tx_Byte(tbyte[1]), .i_Tx_Active(tactive[1]),
    .i_Tx_Done(tdone[1]), .o_Busy(busy[1]));

  assign tactive[0] = act_m[0] | hold_active;
  assign tactive[1] = act_m[1] | hold_active;

  // Memory returns data one cycle after the strobe; TX is busy 5 cycles then pulses done.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ren[k] && raddr[k] < 32'd10) rdata[k] <= mem[raddr[k][3:0]];
      tdone[k] <= 1'b0;
      if (tdv[k]) begin
        tx_cnt[k] <= 5;
        act_m[k]  <= 1'b1;
      end else if (tx_cnt[k] > 1) begin
        tx_cnt[k] <= tx_cnt[k] - 1;
      end else if (tx_cnt[k] == 1) begin
        tx_cnt[k] <= 0;
        act_m[k]  <= 1'b0;
        tdone[k]  <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (tdv[0]) cap0.push_back(tbyte[0]);
    if (tdv[1]) cap1.push_back(tbyte[1]);
    if (ren[0]) rd0.push_back(raddr[0]);
    if (busy[0]) busy_seen0 = 1'b1;
    if ((!ren[0] && raddr[0] != 0) || (!ren[1] && raddr[1] != 0)) addr_bad = 1'b1;
    if (act_m[0] && cap0.size() > 0 && tbyte[0] != cap0[$]) byte_unstable = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc = 0;
    repeat (3) @(negedge clk);
    while ((busy[0] || busy[1]) && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    chk("idle_timeout", 32'(cyc < 600), 32'd1);
    repeat (8) @(negedge clk);
  endtask

  task automatic clear_logs();
    cap0.delete();
    cap1.delete();
    rd0.delete();
    busy_seen0 = 1'b0;
  endtask

  task automatic check_bytes(input string name, input logic [4:0][7:0] exp0, input logic [4:0][7:0] exp1);
    chk({name, "_count0"}, 32'(cap0.size()), 32'd5);
    chk({name, "_count1"}, 32'(cap1.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < cap0.size()) chk({name, "_byte0"}, 32'(cap0[i]), 32'(exp0[i]));
      if (i < cap1.size()) chk({name, "_byte1"}, 32'(cap1[i]), 32'(exp1[i]));
    end
  endtask

  typedef struct {
    logic [7:0]      cmd;
    int              n;
    logic [4:0][7:0] exp0;
    logic [4:0][7:0] exp1;
  } vec_t;

  localparam logic [4:0][7:0] EXP10 = {8'h9A, 8'h78, 8'h56, 8'h34, 8'h12};
  localparam logic [4:0][7:0] EXP9  = {8'h90, 8'h78, 8'h56, 8'h34, 8'h12};

  initial begin
    vec_t vecs [5];
    logic seq_ok;
    int cyc;

    for (int i = 0; i < 10; i++) mem[i] = 4'(i + 1);
    for (int k = 0; k < 2; k++) begin
      act_m[k] = 1'b0;
      tdone[k] = 1'b0;
      tx_cnt[k] = 0;
      rdata[k] = '0;
    end
    addr_bad = 1'b0;
    byte_unstable = 1'b0;
    clear_logs();

    vecs[0] = '{cmd: 8'h07, n: 5, exp0: EXP10, exp1: EXP9};
    vecs[1] = '{cmd: 8'h01, n: 0, exp0: '0, exp1: '0};
    vecs[2] = '{cmd: 8'h00, n: 0, exp0: '0, exp1: '0};
    vecs[3] = '{cmd: 8'h06, n: 0, exp0: '0, exp1: '0};
    vecs[4] = '{cmd: 8'h07, n: 5, exp0: EXP10, exp1: EXP9};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_tx_dv", 32'(tdv[0]), 32'd0);
    chk("rst_read_en", 32'(ren[0]), 32'd0);
    chk("rst_read_addr", raddr[0], 32'd0);
    chk("rst_tx_byte", 32'(tbyte[0]), 32'd0);

    for (int v = 0; v < 5; v++) begin
      clear_logs();
      send_byte(vecs[v].cmd);
      if (vecs[v].n > 0) begin
        wait_idle();
        check_bytes("vec_dump", vecs[v].exp0, vecs[v].exp1);
        chk("vec_reads", 32'(rd0.size()), 32'd10);
      end else begin
        repeat (40) @(negedge clk);
        chk("vec_ign_busy", 32'(busy_seen0), 32'd0);
        chk("vec_ign_tx", 32'(cap0.size() + cap1.size()), 32'd0);
        chk("vec_ign_reads", 32'(rd0.size()), 32'd0);
      end
    end

    // Second DUMP mid-stream must not restart the read sequence.
    clear_logs();
    send_byte(8'h07);
    repeat (30) @(negedge clk);
    send_byte(8'h07);
    wait_idle();
    check_bytes("nodup", EXP10, EXP9);
    seq_ok = (rd0.size() == 10);
    for (int i = 0; i < rd0.size(); i++) if (rd0[i] != 32'(i)) seq_ok = 1'b0;
    chk("nodup_addr_seq", 32'(seq_ok), 32'd1);

    // TX held busy: byte waits in SEND, no further reads.
    clear_logs();
    hold_active = 1'b1;
    send_byte(8'h07);
    repeat (25) @(negedge clk);
    chk("hold_no_tx", 32'(cap0.size()), 32'd0);
    chk("hold_reads", 32'(rd0.size()), 32'd2);
    chk("hold_busy", 32'(busy[0]), 32'd1);
    hold_active = 1'b0;
    wait_idle();
    check_bytes("hold", EXP10, EXP9);
    chk("tx_byte_stable", 32'(byte_unstable), 32'd0);

    // Reset during the third byte's WAIT_DONE, then a clean restart.
    clear_logs();
    send_byte(8'h07);
    cyc = 0;
    while (cap0.size() < 3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_reach", 32'(cyc < 400), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy[0]), 32'd0);
    chk("rst_mid_tx_dv", 32'(tdv[0]), 32'd0);
    chk("rst_mid_read_en", 32'(ren[0]), 32'd0);
    chk("rst_mid_addr", raddr[0], 32'd0);
    chk("rst_mid_tx_byte", 32'(tbyte[0]), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_mid_stay_idle", 32'(busy[0]), 32'd0);
    chk("rst_mid_no_more_tx", 32'(cap0.size()), 32'd3);
    clear_logs();
    send_byte(8'h07);
    wait_idle();
    chk("restart_addr0", (rd0.size() > 0) ? rd0[0] : 32'hFFFF_FFFF, 32'd0);
    check_bytes("restart", EXP10, EXP9);

    chk("addr_zero_when_idle", 32'(addr_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
